mult_seq16: RTL and testbench

- Sequential unsigned shift-and-add multiplier. Sits directly downstream of the 16-bit carry-propagate adder and consumes its sum and carry-out once per cycle.
- Takes two WIDTH-bit operands and produces a 2*WIDTH-bit product, one partial-product bit per clock.
- Uses a start/ready/done handshake so a top-level controller or DIP/LED test harness can launch and read operations.

---
 rtl/mult_seq16_pkg.sv | 14 +
 rtl/mult_seq16_cpa16.sv | 22 ++
 rtl/mult_seq16.sv | 91 +++++++++
 tb/tb_mult_seq16.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq16_pkg.sv
// Shared constants and state encoding for the sequential 16x16 shift-and-add multiplier.
package mult_seq16_pkg;

  localparam int MULT_WIDTH = 16;
  localparam int ITER_LAST  = MULT_WIDTH - 1;

  // 2'b11 is unused; the FSM falls back to IDLE from it.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mult_seq16_cpa16.sv
// 16-bit ripple carry-propagate adder: S/Cout = A + B + Cin.
module mult_seq16_cpa16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic c;

  always_comb begin
    c = Cin;
    S = '0;
    for (int i = 0; i < 16; i++) begin
      S[i] = A[i] ^ B[i] ^ c;
      c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end

endmodule

// File: rtl/mult_seq16.sv
// Unsigned sequential multiplier: one partial-product bit per clock through a 16-bit adder,
// start/ready/done handshake, registered 2*WIDTH product.
module mult_seq16
  import mult_seq16_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [WIDTH-1:0]   acc_hi_nx;
  logic [WIDTH-1:0]   acc_lo_nx;

  // Partial product is gated by the current multiplier LSB; cout feeds the accumulator MSB.
  assign add_b     = acc_lo[0] ? mcand : '0;
  assign acc_hi_nx = {cout, sum[WIDTH-1:1]};
  assign acc_lo_nx = {sum[0], acc_lo[WIDTH-1:1]};

  mult_seq16_cpa16 u_cpa (
    .A    (acc_hi),
    .B    (add_b),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = (cnt == LAST) ? DONE : RUN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc_hi <= acc_hi_nx;
          acc_lo <= acc_lo_nx;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) product <= {acc_hi_nx, acc_lo_nx};
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN) || (state == DONE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_mult_seq16.sv
// Scoreboard bench for mult_seq16: expected products queued at launch, popped on each done pulse.
module tb_mult_seq16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        ready, busy, done;
  logic [31:0] product;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [31:0] sb_q[$];

  mult_seq16 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_done: product=%h, required no done pulse", product);
      end else begin
        logic [31:0] exp;
        exp = sb_q.pop_front();
        if (product !== exp) begin
          n_bad++;
          $display("FAIL sb_product: got %h, required %h", product, exp);
        end
      end
    end
  end

  task automatic launch(input logic [15:0] ia, input logic [15:0] ib);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    sb_q.push_back(32'(ia) * 32'(ib));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the accepting edge (first cycle = 1) until done; checks busy/ready and product stability.
  task automatic wait_done(input string nm, output int n);
    logic hs_ok, stable_ok;
    logic [31:0] p0;
    hs_ok = 1'b1; stable_ok = 1'b1; n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) p0 = product;
      if (done) begin n = i; break; end
      if (busy !== 1'b1 || ready !== 1'b0) hs_ok = 1'b0;
      if (product !== p0) stable_ok = 1'b0;
    end
    n_cmp++;
    if (n == -1) begin
      n_bad++; $display("FAIL %s_timeout: no done within 40 cycles, required done at 17", nm);
    end
    n_cmp++;
    if (hs_ok !== 1'b1) begin
      n_bad++; $display("FAIL %s_busy_ready: busy/ready wrong during RUN, required busy=1 ready=0", nm);
    end
    n_cmp++;
    if (stable_ok !== 1'b1) begin
      n_bad++; $display("FAIL %s_product_stable: product moved before final iteration, required stable", nm);
    end
  endtask

  task automatic chk_latency(input string nm, input int n);
    n_cmp++;
    if (n != 17) begin
      n_bad++; $display("FAIL %s_latency: done at cycle %0d, required 17", nm, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ready, busy, done} !== 3'b100 || product !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: ready/busy/done=%b product=%h, required 100 and 00000000",
               {ready, busy, done}, product);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    launch(16'd3, 16'd5);
    wait_done("basic", n);
    chk_latency("basic", n);
    n_cmp++;
    if (product !== 32'h0000000F) begin
      n_bad++; $display("FAIL basic_product: got %h, required 0000000f", product);
    end
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_ready_after: ready=%b done=%b busy=%b, required 1 0 0", ready, done, busy);
    end
  endtask

  task automatic test_max();
    int n;
    launch(16'hFFFF, 16'hFFFF);
    wait_done("max", n);
    chk_latency("max", n);
    n_cmp++;
    if (product !== 32'hFFFE0001) begin
      n_bad++; $display("FAIL max_product: got %h, required fffe0001", product);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int n;
    launch(16'h1234, 16'h0000);
    wait_done("zero_b", n);
    chk_latency("zero_b", n);
    @(negedge clk);
    launch(16'h0000, 16'hABCD);
    wait_done("zero_a", n);
    chk_latency("zero_a", n);
    @(negedge clk);
    launch(16'h8000, 16'h0002);
    wait_done("msb", n);
    n_cmp++;
    if (product !== 32'h00010000) begin
      n_bad++; $display("FAIL msb_product: got %h, required 00010000", product);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int d0, n_done;
    d0 = done_cnt;
    launch(16'd7, 16'd9);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 5 || i == 17) begin start = 1'b1; a = 16'd2; b = 16'd2; end
      else start = 1'b0;
    end
    start = 1'b0;
    n_done = done_cnt - d0;
    n_cmp++;
    if (n_done != 1) begin
      n_bad++; $display("FAIL ignore_done_count: got %0d pulses, required 1", n_done);
    end
    n_cmp++;
    if (product !== 32'h0000003F || ready !== 1'b1) begin
      n_bad++; $display("FAIL ignore_product: product=%h ready=%b, required 0000003f and 1", product, ready);
    end
  endtask

  task automatic test_reset_abort();
    int n, d0;
    launch(16'h00FF, 16'h0101);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ready, busy, done} !== 3'b100 || product !== 32'h0) begin
      n_bad++;
      $display("FAIL abort_state: ready/busy/done=%b product=%h, required 100 and 00000000",
               {ready, busy, done}, product);
    end
    rst_n = 1'b1;
    sb_q.delete();
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0) begin
      n_bad++; $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - d0);
    end
    launch(16'h00FF, 16'h0101);
    wait_done("restart", n);
    chk_latency("restart", n);
    n_cmp++;
    if (product !== 32'h0000FFFF) begin
      n_bad++; $display("FAIL restart_product: got %h, required 0000ffff", product);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    t1 = -1; t2 = -1;
    @(negedge clk);
    a = 16'd10; b = 16'd20; start = 1'b1;
    sb_q.push_back(32'd200);
    @(posedge clk);
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a = 16'd300; b = 16'd400;
        sb_q.push_back(32'd120000);
      end
      if (i == 19) begin
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++; $display("FAIL b2b_second_accept: busy=%b, required 1", busy);
        end
      end
      if (done) begin
        if (t1 < 0) begin
          t1 = i;
          n_cmp++;
          if (product !== 32'h000000C8) begin
            n_bad++; $display("FAIL b2b_first_product: got %h, required 000000c8", product);
          end
        end else if (t2 < 0) t2 = i;
      end
    end
    n_cmp++;
    if (t1 != 17 || t2 - t1 != 18) begin
      n_bad++; $display("FAIL b2b_spacing: first at %0d gap %0d, required 17 and 18", t1, t2 - t1);
    end
    n_cmp++;
    if (product !== 32'h0001D4C0) begin
      n_bad++; $display("FAIL b2b_second_product: got %h, required 0001d4c0", product);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++; $display("FAIL sb_leftover: %0d expected products never produced, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
